fetch_queue: RTL

- Instruction queue directly downstream of the IFU.
- Captures each fetched instruction and its PC, and presents them in order to decode/control through a valid/ready handshake.
- Discards all buffered wrong-path instructions when the IFU reports a redirect (branch_taken / jump).
- Keeps a saturating count of flushes for debug and performance readout.

---
 rtl/fetch_queue.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction queue between the IFU and decode: in-order valid/ready FIFO of {instr, pc}
// with a redirect flush that drops all buffered wrong-path entries, plus a saturating flush counter.
module fetch_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PTR_W       = 2,
    parameter int unsigned FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_instr,
    input  logic [31:0]            in_pc,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    input  logic                   out_ready,
    output logic [PTR_W:0]         count,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    logic [63:0]            mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                   push, pop;
    logic [63:0]            head;

    assign in_ready    = (count_q != (PTR_W+1)'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign head        = mem_q[rd_ptr_q];
    assign out_instr   = out_valid ? head[63:32] : 32'h0;
    assign out_pc      = out_valid ? head[31:0] : 32'h0;
    assign count       = count_q;
    assign flush_count = flush_cnt_q;

    // A flush suppresses both handshakes: the incoming word is wrong-path.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Storage needs no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {in_instr, in_pc};
        end
    end

endmodule
